// File: rtl/fir_inv.sv
// fir_inv: inverts a TAP-long moving-sum filter.
// Recovers x[n] from y[n] using the previous y and x[n-TAP].
module fir_inv #(
    parameter int TAP = 16,
    parameter int W   = 10
) (
    input  logic         CLOCK_50,
    input  logic         reset,
    input  logic         in_valid,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    output logic [W-1:0] out_data,
    output logic         hist_full
);

    localparam int PW = (TAP > 1) ? $clog2(TAP) : 1;
    localparam int CW = $clog2(TAP + 1);

    typedef enum logic {
        FILL = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [PW-1:0]  ptr_q, ptr_d;
    logic [W-1:0]   y_prev_q, y_prev_d;
    logic [W-1:0]   out_data_q, out_data_d;
    logic           out_valid_q, out_valid_d;
    logic [W-1:0]   hist_q [TAP];
    logic [W-1:0]   hist_d [TAP];
    logic [W-1:0]   x_new;

    // Recovered sample; all terms wrap at W bits.
    assign x_new = in_data - y_prev_q + hist_q[ptr_q];

    // Datapath next-state: history, pointer, y_prev and output register.
    always_comb begin
        hist_d      = hist_q;
        ptr_d       = ptr_q;
        y_prev_d    = y_prev_q;
        out_data_d  = out_data_q;
        out_valid_d = 1'b0;
        if (in_valid) begin
            hist_d[ptr_q] = x_new;
            ptr_d         = (ptr_q == PW'(TAP - 1)) ? '0 : ptr_q + 1'b1;
            y_prev_d      = in_data;
            out_data_d    = x_new;
            out_valid_d   = 1'b1;
        end
    end

    // Warm-up FSM: count samples in FILL, then park in RUN.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            FILL: begin
                if (in_valid) begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CW'(TAP - 1)) begin
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                state_d = RUN;
            end
            default: begin
                state_d = FILL;
            end
        endcase
    end

    // State registers; reset wipes history and discards the input.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q     <= FILL;
            cnt_q       <= '0;
            ptr_q       <= '0;
            y_prev_q    <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            for (int i = 0; i < TAP; i++) begin
                hist_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            ptr_q       <= ptr_d;
            y_prev_q    <= y_prev_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            for (int i = 0; i < TAP; i++) begin
                hist_q[i] <= hist_d[i];
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign hist_full = (state_q == RUN);

endmodule

// File: tb/tb_fir_inv.sv
// tb_fir_inv: drives y = moving sum of a chosen x sequence
// and expects fir_inv to return that x sequence.
module tb_fir_inv;

    localparam int TAP = 16;
    localparam int W   = 10;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         in_valid = 1'b0;
    logic [W-1:0] in_data = '0;
    logic         out_valid;
    logic [W-1:0] out_data;
    logic         hist_full;

    int passed = 0;
    int total  = 0;

    logic [W-1:0] xs [$];
    logic [W-1:0] last_out = '0;

    always #5 clk = ~clk;

    fir_inv #(.TAP(TAP), .W(W)) dut (
        .CLOCK_50 (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in_data  (in_data),
        .out_valid(out_valid),
        .out_data (out_data),
        .hist_full(hist_full)
    );

    task automatic check(input string tag, input logic [W-1:0] obs,
                         input logic [W-1:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got %0d want %0d (t=%0t)", tag, obs, exp, $time);
    endtask

    function automatic logic [W-1:0] y_of();
        logic [W-1:0] s;
        int lo;
        s  = '0;
        lo = (xs.size() > TAP) ? xs.size() - TAP : 0;
        for (int i = lo; i < xs.size(); i++) s = s + xs[i];
        return s;
    endfunction

    function automatic logic [W-1:0] full_exp();
        return W'(xs.size() >= TAP);
    endfunction

    task automatic send(input logic [W-1:0] x);
        xs.push_back(x);
        in_valid = 1'b1;
        in_data  = y_of();
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("valid", W'(out_valid), W'(1'b1));
        check("data", out_data, x);
        check("full", W'(hist_full), full_exp());
        last_out = x;
    endtask

    task automatic idle();
        in_valid = 1'b0;
        in_data  = W'($urandom);
        @(posedge clk);
        #1;
        check("idle_valid", W'(out_valid), W'(1'b0));
        check("idle_hold", out_data, last_out);
        check("idle_full", W'(hist_full), full_exp());
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        in_valid = 1'($urandom_range(0, 1));
        in_data  = W'($urandom);
        @(posedge clk);
        #1;
        reset    = 1'b0;
        in_valid = 1'b0;
        xs.delete();
        last_out = '0;
        check("rst_valid", W'(out_valid), W'(1'b0));
        check("rst_data", out_data, '0);
        check("rst_full", W'(hist_full), W'(1'b0));
    endtask

    initial begin
        do_reset();
        for (int i = 0; i < 20; i++) idle();

        send(10'd5);
        for (int i = 0; i < 35; i++) send(10'd0);

        do_reset();
        for (int i = 0; i < 32; i++) send(10'd1);

        do_reset();
        for (int i = 0; i < 40; i++) send(10'd1023);

        do_reset();
        for (int i = 0; i < 96; i++) begin
            if ((i % 4 == 0) || (i % 4 == 3)) send(10'd1);
            else idle();
        end

        do_reset();
        for (int i = 0; i < 8; i++) send(10'd1);
        do_reset();
        send(10'd3);
        for (int i = 0; i < 18; i++) send(10'd1);

        do_reset();
        for (int i = 0; i < 400; i++) begin
            if (i == 200) do_reset();
            if ($urandom_range(0, 9) == 0) idle();
            else if ($urandom_range(0, 4) == 0) send('0);
            else send(W'($urandom));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/fir_inv.md
FIR_INV -- requirements
Module: fir_inv

Interface
REQ-001 Parameter TAP, default 16, gives the moving-sum window length being inverted; the legal range is 2..64.
REQ-002 Parameter W, default 10, gives the sample width in bits.
REQ-003 CLOCK_50  input  1  the single system clock; all state changes on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  qualifies in_data for the current cycle.
REQ-006 in_data  input  W  moving-sum sample y[n], equal to the sum of the last TAP inputs x, modulo 2^W.
REQ-007 out_valid  output  1  qualifies out_data.
REQ-008 out_data  output  W  recovered sample x[n].
REQ-009 hist_full  output  1  high once TAP samples have been accepted since reset (warm-up complete).

Function
REQ-010 The block SHALL accept a sample on every cycle where in_valid=1, with no backpressure.
REQ-011 For each accepted sample, the block SHALL compute x[n] = in_data - y_prev + hist_oldest, modulo 2^W, where hist_oldest is x[n-TAP].
REQ-012 All arithmetic SHALL wrap modulo 2^W: no saturation and no carry out.
REQ-013 out_data and out_valid SHALL be registered, so out_valid=1 exactly one cycle after each accepted sample.
REQ-014 On cycles with in_valid=0, the next cycle SHALL have out_valid=0.
REQ-015 On cycles with in_valid=0, out_data SHALL hold its last value and no internal state SHALL change.
REQ-016 The history SHALL be a TAP-entry circular buffer of recovered samples, indexed by a write pointer.
REQ-017 On each accepted sample, the entry at the write pointer SHALL be read as hist_oldest and then overwritten with the new x[n] in the same cycle.
REQ-018 The write pointer SHALL advance by one per accepted sample and wrap from TAP-1 to 0.
REQ-019 y_prev SHALL be loaded with in_data on each accepted sample.
REQ-020 A warm-up state machine SHALL have two states, FILL and RUN.
REQ-021 The state machine SHALL be in FILL after reset, with a sample counter at 0.
REQ-022 In FILL, the counter SHALL increment per accepted sample.
REQ-023 The state machine SHALL move to RUN on the cycle the TAP-th sample is accepted; hist_full=1 from the following cycle.
REQ-024 RUN SHALL be held until reset, and the counter SHALL not advance in RUN.
REQ-025 Because unwritten history entries are zero after reset, recovered values in FILL SHALL already be exact; hist_full is informational only.
REQ-026 Zero-valued samples SHALL be processed identically to any other sample.

Reset
REQ-027 When reset=1 at a rising edge, out_data=0, out_valid=0, hist_full=0, y_prev=0, the write pointer=0, the counter=0, the state=FILL, and all TAP history entries=0.
REQ-028 reset SHALL take priority over in_valid; a sample presented in a reset cycle SHALL be discarded.
REQ-029 Reset asserted mid-stream SHALL fully discard the history, and the first sample after reset SHALL be treated as n=0.

Verification
REQ-030 Reset, then hold in_valid=0 for 20 cycles -> out_valid=0, out_data=0, hist_full=0 throughout.
REQ-031 Impulse (TAP=16): feed y=5 sixteen times then y=0 twenty times -> out_data = 5, then 35 consecutive 0s; hist_full rises after the 16th sample.
REQ-032 Step: feed y = 1,2,...,16, then 16 repeated -> every out_data=1, each one cycle after its input.
REQ-033 Wrap: a constant x=1023 gives y = 1023, 1022, 1021, ... (mod 1024), saturating at 1008 once the window is full -> every out_data=1023.
REQ-034 Gaps: repeat the step stimulus with in_valid toggling 1,0,0,1 -> the out_valid pattern matches the in_valid pattern delayed one cycle, every out_data=1, and out_data holds its value during gaps.
REQ-035 Mid-stream reset: after 8 step samples assert reset for 1 cycle, then feed y=3 -> out_data=3, hist_full=0, and the counter restarts from 0.
